// File: rtl/ping_pong_counter_multi_mode.sv
// Multi-mode ping-pong counter (bounce / wrap-up / wrap-down / hold) with a
// debounced direction button and a 4-digit seven-segment readout.
module ping_pong_counter_multi_mode #(
  parameter int WIDTH     = 8,
  parameter int TICK_BITS = 26,
  parameter int SCAN_BITS = 16,
  parameter int DEB_LEN   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             flip,
  input  logic [1:0]       mode,
  input  logic [3:0]       step,
  input  logic [WIDTH-1:0] max,
  input  logic [WIDTH-1:0] min,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             range_err,
  output logic [3:0]       AN,
  output logic [6:0]       segs
);

  // At least 5 bits so a 4-bit step never truncates, and one bit above WIDTH.
  localparam int AW = (WIDTH + 1 > 5) ? WIDTH + 1 : 5;
  localparam logic [TICK_BITS-1:0] TICK_ONE = 1;
  localparam logic [SCAN_BITS-1:0] SCAN_ONE = 1;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_UP   = 7'b1011100;
  localparam logic [6:0] SEG_DOWN = 7'b1100011;

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  logic [TICK_BITS-1:0] tick_cnt_r;
  logic [SCAN_BITS-1:0] scan_cnt_r;
  logic [1:0]           scan_idx_r;
  logic [DEB_LEN-1:0]   deb_r;
  logic                 deb_q_r;
  logic                 flip_p_r;
  logic [WIDTH-1:0]     count_r;
  logic                 dir_r;

  logic             tick_s, debounced_s, active_s, at_max_s, at_min_s, eff_dir_s;
  logic [WIDTH-1:0] count_nx_s;
  logic             dir_nx_s;
  logic [AW-1:0]    cnt_w_s, max_w_s, min_w_s, s_w_s;
  logic [AW-1:0]    up_sum_s, dn_floor_s, dn_diff_s;
  logic [AW-1:0]    sat_up_s, sat_dn_s, wrap_up_s, wrap_dn_s;
  logic [7:0]       cnt8_s;
  logic [6:0]       digit_s;
  mode_e            mode_s;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      4'hF:    hex7 = 7'b0001110;
      default: hex7 = 7'b1111111;
    endcase
  endfunction

  assign mode_s      = mode_e'(mode);
  assign tick_s      = &tick_cnt_r;
  assign debounced_s = &deb_r;
  assign range_err   = (min >= max) | (count_r < min) | (count_r > max);
  assign active_s    = enable & ~range_err;
  assign at_max_s    = dir_r & (count_r == max);
  assign at_min_s    = ~dir_r & (count_r == min);
  assign eff_dir_s   = dir_r ^ flip_p_r;

  assign cnt_w_s    = {{(AW-WIDTH){1'b0}}, count_r};
  assign max_w_s    = {{(AW-WIDTH){1'b0}}, max};
  assign min_w_s    = {{(AW-WIDTH){1'b0}}, min};
  assign s_w_s      = (step == 4'd0) ? {{(AW-1){1'b0}}, 1'b1} : {{(AW-4){1'b0}}, step};
  assign up_sum_s   = cnt_w_s + s_w_s;
  assign dn_floor_s = min_w_s + s_w_s;
  assign dn_diff_s  = cnt_w_s - s_w_s;
  // Down results are only used when count >= min + s, so dn_diff_s never underflows there.
  assign sat_up_s   = (up_sum_s > max_w_s) ? max_w_s : up_sum_s;
  assign sat_dn_s   = (cnt_w_s < dn_floor_s) ? min_w_s : dn_diff_s;
  assign wrap_up_s  = (up_sum_s > max_w_s) ? min_w_s : up_sum_s;
  assign wrap_dn_s  = (cnt_w_s < dn_floor_s) ? max_w_s : dn_diff_s;

  assign count = count_r;
  assign dir   = dir_r;

  // Next count/direction from the active mode
  always_comb begin
    count_nx_s = count_r;
    dir_nx_s   = dir_r;
    if (active_s) begin
      case (mode_s)
        MODE_BOUNCE: begin
          if (tick_s) begin
            if (at_max_s) begin
              dir_nx_s   = 1'b0;
              count_nx_s = sat_dn_s[WIDTH-1:0];
            end else if (at_min_s) begin
              dir_nx_s   = 1'b1;
              count_nx_s = sat_up_s[WIDTH-1:0];
            end else begin
              dir_nx_s   = eff_dir_s;
              count_nx_s = eff_dir_s ? sat_up_s[WIDTH-1:0] : sat_dn_s[WIDTH-1:0];
            end
          end else if (flip_p_r) begin
            dir_nx_s = ~dir_r;
          end else begin
            dir_nx_s = dir_r;
          end
        end
        MODE_UP: begin
          if (tick_s) begin
            dir_nx_s   = 1'b1;
            count_nx_s = wrap_up_s[WIDTH-1:0];
          end else begin
            dir_nx_s = dir_r;
          end
        end
        MODE_DOWN: begin
          if (tick_s) begin
            dir_nx_s   = 1'b0;
            count_nx_s = wrap_dn_s[WIDTH-1:0];
          end else begin
            dir_nx_s = dir_r;
          end
        end
        default: begin
          count_nx_s = count_r;
          dir_nx_s   = dir_r;
        end
      endcase
    end else begin
      count_nx_s = count_r;
      dir_nx_s   = dir_r;
    end
  end

  // Counter state, tick divider and button debounce / one-pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r    <= min;
      dir_r      <= 1'b1;
      tick_cnt_r <= '0;
      deb_r      <= '0;
      deb_q_r    <= 1'b0;
      flip_p_r   <= 1'b0;
    end else begin
      count_r    <= count_nx_s;
      dir_r      <= dir_nx_s;
      tick_cnt_r <= tick_cnt_r + TICK_ONE;
      deb_r      <= {deb_r[DEB_LEN-2:0], flip};
      deb_q_r    <= debounced_s;
      flip_p_r   <= debounced_s & ~deb_q_r;
    end
  end

  // Display scan divider and digit index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt_r <= '0;
      scan_idx_r <= 2'd0;
    end else begin
      scan_cnt_r <= scan_cnt_r + SCAN_ONE;
      if (&scan_cnt_r) begin
        scan_idx_r <= scan_idx_r + 2'd1;
      end else begin
        scan_idx_r <= scan_idx_r;
      end
    end
  end

  // Digit select and segment pattern for the current scan position
  always_comb begin
    cnt8_s                = 8'd0;
    cnt8_s[WIDTH-1:0]     = count_r;
    AN                    = 4'b1111;
    digit_s               = 7'b1111111;
    case (scan_idx_r)
      2'd0: begin
        AN      = 4'b1110;
        digit_s = hex7(cnt8_s[3:0]);
      end
      2'd1: begin
        AN      = 4'b1101;
        digit_s = hex7(cnt8_s[7:4]);
      end
      2'd2: begin
        AN      = 4'b1011;
        digit_s = dir_r ? SEG_UP : SEG_DOWN;
      end
      default: begin
        AN      = 4'b0111;
        digit_s = dir_r ? SEG_UP : SEG_DOWN;
      end
    endcase
    segs = range_err ? SEG_DASH : digit_s;
  end

endmodule
